// File: rtl/wb_arbiter_if.sv
// Bus bundle between the register-file write-side arbiter and its neighbours.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface wb_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
);
  logic                       p_we;
  logic [ADDRESS_WIDTH-1:0]   p_rd;
  logic [DATA_WIDTH-1:0]      p_wd;
  logic                       l_valid;
  logic                       l_ready;
  logic [ADDRESS_WIDTH-1:0]   l_rd;
  logic [DATA_WIDTH-1:0]      l_wd;
  logic                       iss_valid;
  logic [ADDRESS_WIDTH-1:0]   iss_rd;
  logic [ADDRESS_WIDTH-1:0]   ad1;
  logic [ADDRESS_WIDTH-1:0]   ad2;
  logic                       haz1;
  logic                       haz2;
  logic [ADDRESS_WIDTH-1:0]   ad3;
  logic                       we3;
  logic [DATA_WIDTH-1:0]      wd3;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       sb_err;
`ifdef WB_BYPASS_EN
  logic                       fwd1_valid;
  logic                       fwd2_valid;
  logic [DATA_WIDTH-1:0]      fwd1_data;
  logic [DATA_WIDTH-1:0]      fwd2_data;
`endif

  modport slave (
    input  p_we, p_rd, p_wd, l_valid, l_rd, l_wd, iss_valid, iss_rd, ad1, ad2,
`ifdef WB_BYPASS_EN
    output fwd1_valid, fwd2_valid, fwd1_data, fwd2_data,
`endif
    output l_ready, haz1, haz2, ad3, we3, wd3, fifo_count, sb_err
  );

  modport master (
    output p_we, p_rd, p_wd, l_valid, l_rd, l_wd, iss_valid, iss_rd, ad1, ad2,
`ifdef WB_BYPASS_EN
    input  fwd1_valid, fwd2_valid, fwd1_data, fwd2_data,
`endif
    input  l_ready, haz1, haz2, ad3, we3, wd3, fifo_count, sb_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback over a long-latency result FIFO,
// plus a pending-write scoreboard. Define WB_BYPASS_EN to add decode forwarding outputs.
module wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2 ** ADDRESS_WIDTH;

  logic [ADDRESS_WIDTH-1:0] fifo_rd [DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_wd [DEPTH];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic [NREG-1:0]          pending;
  logic [NREG-1:0]          pending_nxt;

  logic                     sel_pipe;
  logic                     pop;
  logic                     push;
  logic                     sb_set;
  logic                     sb_clr;
  logic [ADDRESS_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0]    head_wd;

  logic [ADDRESS_WIDTH-1:0] ad3_q;
  logic                     we3_q;
  logic [DATA_WIDTH-1:0]    wd3_q;
  logic                     sb_err_q;

  assign head_rd  = fifo_rd[rd_ptr];
  assign head_wd  = fifo_wd[rd_ptr];

  // A pipeline write to x0 is discarded, so it leaves the port free for the FIFO.
  assign sel_pipe = bus.p_we && (bus.p_rd != '0);
  assign pop      = !sel_pipe && (count != '0);

  // Pop is resolved first, so a full FIFO still takes a result on a draining cycle.
  assign bus.l_ready = rst_n && ((count < CW'(DEPTH)) || pop);
  assign push        = bus.l_valid && bus.l_ready;

  assign sb_set = bus.iss_valid && (bus.iss_rd != '0);
  assign sb_clr = pop && (head_rd != '0);

  always_comb begin
    pending_nxt = pending;
    if (sb_clr) pending_nxt[head_rd] = 1'b0;
    if (sb_set) pending_nxt[bus.iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      sb_err_q <= 1'b0;
      we3_q    <= 1'b0;
      ad3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr] <= bus.l_rd;
        fifo_wd[wr_ptr] <= bus.l_wd;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      pending <= pending_nxt;
      if (sb_set && pending[bus.iss_rd]) sb_err_q <= 1'b1;

      if (sel_pipe) begin
        we3_q <= 1'b1;
        ad3_q <= bus.p_rd;
        wd3_q <= bus.p_wd;
      end else if (sb_clr) begin
        we3_q <= 1'b1;
        ad3_q <= head_rd;
        wd3_q <= head_wd;
      end else begin
        we3_q <= 1'b0;
      end
    end
  end

  assign bus.ad3        = ad3_q;
  assign bus.we3        = we3_q;
  assign bus.wd3        = wd3_q;
  assign bus.sb_err     = sb_err_q;
  assign bus.fifo_count = count;

`ifdef WB_BYPASS_EN
  logic fifo_src;

  always_ff @(posedge clk) begin
    if (!rst_n) fifo_src <= 1'b0;
    else        fifo_src <= !sel_pipe && sb_clr;
  end

  assign bus.fwd1_valid = we3_q && (ad3_q == bus.ad1) && (bus.ad1 != '0);
  assign bus.fwd2_valid = we3_q && (ad3_q == bus.ad2) && (bus.ad2 != '0);
  assign bus.fwd1_data  = wd3_q;
  assign bus.fwd2_data  = wd3_q;

  // The in-flight FIFO write already carries the value decode is waiting on.
  assign bus.haz1 = (bus.ad1 != '0) && pending[bus.ad1] && !(bus.fwd1_valid && fifo_src);
  assign bus.haz2 = (bus.ad2 != '0) && pending[bus.ad2] && !(bus.fwd2_valid && fifo_src);
`else
  assign bus.haz1 = (bus.ad1 != '0) && pending[bus.ad1];
  assign bus.haz2 = (bus.ad2 != '0) && pending[bus.ad2];
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: pipeline writes, FIFO drain order,
// full push/pop, scoreboard hazards and errors, and reset mid-operation.
module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  wb_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) bus ();

  wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p_we = 0; bus.p_rd = '0; bus.p_wd = '0;
    bus.l_valid = 0; bus.l_rd = '0; bus.l_wd = '0;
    bus.iss_valid = 0; bus.iss_rd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.ad1 = '0; bus.ad2 = '0;
    rst_n = 0;
    tick(); tick();
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %0h exp 0", bus.we3); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.l_ready !== 1'b0) begin errors++; $display("FAIL reset_l_ready got %0h exp 0", bus.l_ready); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %0h exp 0", bus.sb_err); end
    rst_n = 1;
    #1;
    checks++; if (bus.l_ready !== 1'b1) begin errors++; $display("FAIL post_reset_l_ready got %0h exp 1", bus.l_ready); end
  endtask

  task automatic test_pipeline();
    bus.p_we = 1; bus.p_rd = 5'd5; bus.p_wd = 32'hDEADBEEF;
    tick();
    checks++; if (bus.we3 !== 1'b1) begin errors++; $display("FAIL pipe_we3 got %0h exp 1", bus.we3); end
    checks++; if (bus.ad3 !== 5'd5) begin errors++; $display("FAIL pipe_ad3 got %0d exp 5", bus.ad3); end
    checks++; if (bus.wd3 !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_wd3 got %0h exp deadbeef", bus.wd3); end
    bus.p_rd = '0; bus.p_wd = 32'h1111;
    tick();
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL pipe_x0_we3 got %0h exp 0", bus.we3); end
    bus.p_we = 0;
  endtask

  task automatic test_issue_result();
    bus.iss_valid = 1; bus.iss_rd = 5'd7; bus.ad1 = 5'd7; bus.ad2 = 5'd7;
    tick();
    bus.iss_valid = 0;
    #1;
    checks++; if (bus.haz1 !== 1'b1) begin errors++; $display("FAIL issue_haz1 got %0h exp 1", bus.haz1); end
    checks++; if (bus.haz2 !== 1'b1) begin errors++; $display("FAIL issue_haz2 got %0h exp 1", bus.haz2); end
    bus.p_we = 1; bus.p_rd = 5'd7; bus.p_wd = 32'h55;
    tick();
    checks++; if (bus.we3 !== 1'b1 || bus.ad3 !== 5'd7) begin errors++; $display("FAIL pipe_to_pending got we3=%0h ad3=%0d exp 1/7", bus.we3, bus.ad3); end
    checks++; if (bus.haz1 !== 1'b1) begin errors++; $display("FAIL pipe_keeps_pending got %0h exp 1", bus.haz1); end
    bus.p_we = 0; bus.l_valid = 1; bus.l_rd = 5'd7; bus.l_wd = 32'h1234;
    tick();
    bus.l_valid = 0;
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL result_count got %0d exp 1", bus.fifo_count); end
    checks++; if (bus.haz1 !== 1'b1) begin errors++; $display("FAIL result_buffered_haz1 got %0h exp 1", bus.haz1); end
    tick();
    checks++; if (bus.we3 !== 1'b1 || bus.ad3 !== 5'd7 || bus.wd3 !== 32'h1234) begin
      errors++; $display("FAIL result_write got we3=%0h ad3=%0d wd3=%0h exp 1/7/1234", bus.we3, bus.ad3, bus.wd3); end
    checks++; if (bus.haz1 !== 1'b0) begin errors++; $display("FAIL result_haz1_clear got %0h exp 0", bus.haz1); end
    tick();
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL result_idle_we3 got %0h exp 0", bus.we3); end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 6; i++) begin
      bus.p_we = 1; bus.p_rd = 5'(i + 1); bus.p_wd = 32'(100 + i);
      bus.l_valid = (i < 4); bus.l_rd = 5'(10 + i); bus.l_wd = 32'hA0 + 32'(i);
      #1;
      checks++; if (bus.l_ready !== (i < 4)) begin errors++; $display("FAIL cont_l_ready[%0d] got %0h exp %0h", i, bus.l_ready, (i < 4)); end
      tick();
      checks++; if (bus.we3 !== 1'b1 || bus.ad3 !== 5'(i + 1) || bus.wd3 !== 32'(100 + i)) begin
        errors++; $display("FAIL cont_pipe[%0d] got we3=%0h ad3=%0d wd3=%0h", i, bus.we3, bus.ad3, bus.wd3); end
      checks++; if (bus.fifo_count !== ((i < 3) ? 3'(i + 1) : 3'd4)) begin errors++; $display("FAIL cont_count[%0d] got %0d", i, bus.fifo_count); end
    end
    bus.l_valid = 0;
    #1;
    checks++; if (bus.l_ready !== 1'b0) begin errors++; $display("FAIL cont_full_l_ready got %0h exp 0", bus.l_ready); end
    bus.p_we = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (bus.we3 !== 1'b1 || bus.ad3 !== 5'(10 + j) || bus.wd3 !== 32'hA0 + 32'(j)) begin
        errors++; $display("FAIL drain[%0d] got we3=%0h ad3=%0d wd3=%0h exp 1/%0d/%0h", j, bus.we3, bus.ad3, bus.wd3, 10 + j, 32'hA0 + j); end
    end
    tick();
    checks++; if (bus.we3 !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL drain_done got we3=%0h count=%0d exp 0/0", bus.we3, bus.fifo_count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      bus.p_we = 1; bus.p_rd = 5'd1;
      bus.l_valid = 1; bus.l_rd = 5'(16 + i); bus.l_wd = 32'hB0 + 32'(i);
      tick();
    end
    bus.p_we = 0; bus.l_rd = 5'd20; bus.l_wd = 32'hB4;
    #1;
    checks++; if (bus.l_ready !== 1'b1) begin errors++; $display("FAIL full_pop_l_ready got %0h exp 1", bus.l_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count[%0d] got %0d exp 4", k, bus.fifo_count); end
      checks++; if (bus.ad3 !== 5'(16 + k) || bus.wd3 !== 32'hB0 + 32'(k)) begin errors++; $display("FAIL full_pushpop_data[%0d] got ad3=%0d wd3=%0h", k, bus.ad3, bus.wd3); end
      bus.l_rd = 5'd21; bus.l_wd = 32'hB5;
    end
    bus.l_valid = 0; bus.p_we = 1; bus.p_rd = '0;
    for (int k = 2; k < 6; k++) begin
      tick();
      bus.p_we = 0;
      checks++; if (bus.we3 !== 1'b1 || bus.ad3 !== 5'(16 + k) || bus.wd3 !== 32'hB0 + 32'(k)) begin
        errors++; $display("FAIL full_drain[%0d] got we3=%0h ad3=%0d wd3=%0h", k, bus.we3, bus.ad3, bus.wd3); end
    end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL full_drain_count got %0d exp 0", bus.fifo_count); end
  endtask

  task automatic test_error_x0();
    bus.iss_valid = 1; bus.iss_rd = 5'd3;
    tick();
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL err_first_issue got %0h exp 0", bus.sb_err); end
    tick();
    bus.iss_valid = 0;
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL err_double_issue got %0h exp 1", bus.sb_err); end
    tick(); tick();
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0h exp 1", bus.sb_err); end
    bus.iss_valid = 1; bus.iss_rd = '0; bus.ad1 = '0; bus.ad2 = 5'd3;
    tick();
    bus.iss_valid = 0;
    checks++; if (bus.haz1 !== 1'b0) begin errors++; $display("FAIL x0_haz got %0h exp 0", bus.haz1); end
    checks++; if (bus.haz2 !== 1'b1) begin errors++; $display("FAIL pending3_haz2 got %0h exp 1", bus.haz2); end
    bus.l_valid = 1; bus.l_rd = '0; bus.l_wd = 32'h77;
    tick();
    bus.l_valid = 0;
    tick();
    checks++; if (bus.we3 !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL x0_entry_dropped got we3=%0h count=%0d exp 0/0", bus.we3, bus.fifo_count); end
  endtask

  task automatic test_reset_mid();
    bus.iss_valid = 1; bus.iss_rd = 5'd9; bus.ad1 = 5'd9;
    tick();
    bus.iss_valid = 0;
    for (int i = 0; i < 3; i++) begin
      bus.p_we = 1; bus.p_rd = 5'd2;
      bus.l_valid = 1; bus.l_rd = 5'd9; bus.l_wd = 32'(i);
      tick();
    end
    bus.l_valid = 0; bus.p_we = 0;
    checks++; if (bus.fifo_count !== 3'd3 || bus.haz1 !== 1'b1) begin errors++; $display("FAIL pre_reset got count=%0d haz1=%0h exp 3/1", bus.fifo_count, bus.haz1); end
    rst_n = 0;
    tick();
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL midrst_we3 got %0h exp 0", bus.we3); end
    checks++; if (bus.haz1 !== 1'b0) begin errors++; $display("FAIL midrst_haz9 got %0h exp 0", bus.haz1); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL midrst_sb_err got %0h exp 0", bus.sb_err); end
    rst_n = 1;
    tick();
    checks++; if (bus.we3 !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL post_midrst got we3=%0h count=%0d exp 0/0", bus.we3, bus.fifo_count); end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_issue_result();
    test_contention();
    test_full_push_pop();
    test_error_x0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
